// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and data
// requesters; one access at a time through IDLE -> ISSUE -> WAIT -> DONE.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [15:0] addr_i,
    output logic        ack_i,
    input  logic        req_d,
    input  logic        we_d,
    input  logic        byte_d,
    input  logic [15:0] addr_d,
    input  logic [15:0] wdata_d,
    output logic        ack_d,
    output logic [15:0] rdata,
    output logic        misalign,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic        last_data, last_data_nxt;
    logic        grant_data, grant_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        take, capture;
    logic        lat_we, lat_byte, lat_lsb;

    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_we, sel_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_data  <= 1'b1;
            grant_data <= 1'b0;
            cnt        <= 4'd0;
        end else begin
            state      <= state_nxt;
            last_data  <= last_data_nxt;
            grant_data <= grant_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // On a tie the side that was not served last wins; a lone requester always wins.
    always_comb begin
        state_nxt     = state;
        last_data_nxt = last_data;
        grant_nxt     = grant_data;
        cnt_nxt       = cnt;
        take          = 1'b0;
        capture       = 1'b0;
        mem_en        = 1'b0;
        ack_i         = 1'b0;
        ack_d         = 1'b0;
        misalign      = 1'b0;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    take          = 1'b1;
                    grant_nxt     = req_d & (~req_i | ~last_data);
                    last_data_nxt = req_d & (~req_i | ~last_data);
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                cnt_nxt   = CNT_INIT;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    capture   = ~lat_we;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                ack_i     = ~grant_data;
                ack_d     = grant_data;
                misalign  = ~lat_byte & lat_lsb;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_addr  = grant_nxt ? addr_d : addr_i;
    assign sel_wdata = grant_nxt ? wdata_d : 16'h0000;
    assign sel_we    = grant_nxt & we_d;
    assign sel_byte  = grant_nxt & byte_d;

    // Memory-side command is registered at grant time and held until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= 15'h0000;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_wdata <= 16'h0000;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_lsb   <= 1'b0;
            rdata     <= 16'h0000;
        end else begin
            if (take) begin
                mem_addr  <= sel_addr[15:1];
                mem_we    <= sel_we;
                mem_be    <= sel_byte ? (sel_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_wdata <= sel_byte ? {sel_wdata[7:0], sel_wdata[7:0]} : sel_wdata;
                lat_we    <= sel_we;
                lat_byte  <= sel_byte;
                lat_lsb   <= sel_addr[0];
            end
            if (capture) begin
                rdata <= lat_byte ? {8'h00, (lat_lsb ? mem_rdata[15:8] : mem_rdata[7:0])}
                                  : mem_rdata;
            end
        end
    end

endmodule
